// File: rtl/rv_writeback_unit.sv
// Writeback stage: picks ALU/load/PC+4 result and drives the regfile write.
// Optional load-response timeout enabled by defining RV_WB_TIMEOUT_EN.
module rv_writeback_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [1:0]      in_wbsel,
    input  logic            in_regwen,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] wb_inst,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_wen,
    output logic            wb_busy,
    output logic            wb_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        COMMIT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc4_q;
    logic [1:0]      wbsel_q;
    logic            regwen_q;
    logic [XLEN-1:0] mem_q;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] sel_data;
    logic            wen_c;
    logic            timed_out;
    logic [2:0]      funct3;

    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rv_writeback_unit: XLEN must be 32, TIMEOUT_CYCLES >= 1");
    end

    assign in_ready = (state == IDLE);
    assign wb_busy  = (state != IDLE);
    assign funct3   = inst_q[14:12];

`ifdef RV_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          to_q;
    logic          err_q;

    assign timed_out = to_q;
    assign wb_err    = err_q;
`else
    assign timed_out = 1'b0;
    assign wb_err    = 1'b0;
`endif

    // Extract and extend the addressed lane of the load response
    always_comb begin
        ld_byte = mem_rdata[7:0];
        unique case (alu_q[1:0])
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext  = mem_rdata;
        unique case (1'b1)
            (funct3 == 3'b000): ld_ext = {{24{ld_byte[7]}}, ld_byte};
            (funct3 == 3'b100): ld_ext = {24'd0, ld_byte};
            (funct3 == 3'b001): ld_ext = {{16{ld_half[15]}}, ld_half};
            (funct3 == 3'b101): ld_ext = {16'd0, ld_half};
            default:            ld_ext = mem_rdata;
        endcase
    end

    // Result mux and write qualification; x0 is never written
    always_comb begin
        sel_data = '0;
        unique case (1'b1)
            (wbsel_q == 2'd0): sel_data = alu_q;
            (wbsel_q == 2'd1): sel_data = mem_q;
            (wbsel_q == 2'd2): sel_data = pc4_q;
            default:           sel_data = '0;
        endcase
        wen_c = regwen_q && (inst_q[11:7] != 5'd0) && (wbsel_q != 2'd3);
    end

    // Handshake, load wait and one-cycle commit FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            inst_q   <= '0;
            alu_q    <= '0;
            pc4_q    <= '0;
            wbsel_q  <= '0;
            regwen_q <= 1'b0;
            mem_q    <= '0;
            wb_inst  <= '0;
            wb_data  <= '0;
            wb_wen   <= 1'b0;
`ifdef RV_WB_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            wb_wen <= 1'b0;
`ifdef RV_WB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        inst_q   <= in_inst;
                        alu_q    <= in_alu;
                        pc4_q    <= in_pc4;
                        wbsel_q  <= in_wbsel;
                        regwen_q <= in_regwen;
`ifdef RV_WB_TIMEOUT_EN
                        cnt_q    <= '0;
                        to_q     <= 1'b0;
`endif
                        state <= (in_wbsel == 2'd1) ? WAIT_MEM : COMMIT;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        mem_q <= ld_ext;
                        state <= COMMIT;
                    end
`ifdef RV_WB_TIMEOUT_EN
                    else if (cnt_q == LIMIT) begin
                        to_q  <= 1'b1;
                        state <= COMMIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                COMMIT: begin
                    wb_inst <= inst_q;
                    wb_data <= timed_out ? '0 : sel_data;
                    wb_wen  <= wen_c && !timed_out;
`ifdef RV_WB_TIMEOUT_EN
                    err_q   <= to_q;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
